// File: rtl/sram_dp_be.sv
// Simple dual-port SRAM with byte-lane write enables, registered read and self-clearing init.
// Optional per-lane even parity with error injection: define SRAM_DP_BE_PARITY_EN.
module sram_dp_be #(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 8,
    parameter int LANE_W      = 4,
    parameter int WRITE_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/LANE_W-1:0]   wr_be,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid
`ifdef SRAM_DP_BE_PARITY_EN
    ,
    input  logic                       wr_par_flip,
    output logic                       rd_err
`endif
);

    localparam int NLANE = DATA_W / LANE_W;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic run;
    logic do_wr;
    logic do_rd;
    logic collide;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] rd_word;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state: compare against the last address so no wrap is relied on
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            S_INIT: begin
                if (cnt == LAST) begin
                    state_nx = S_RUN;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_RUN: begin
                state_nx = S_RUN;
            end
            default: begin
                state_nx = S_INIT;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs of the sequencer
    always_comb begin
        init_busy = 1'b1;
        run       = 1'b0;
        unique case (state)
            S_INIT: begin
                init_busy = 1'b1;
                run       = 1'b0;
            end
            S_RUN: begin
                init_busy = 1'b0;
                run       = 1'b1;
            end
            default: begin
                init_busy = 1'b1;
                run       = 1'b0;
            end
        endcase
    end

    assign do_wr   = run & wr_en;
    assign do_rd   = run & rd_en;
    assign collide = wr_en & rd_en & (wr_addr == rd_addr);
    assign old_word = mem[rd_addr];

    // Collision under write-first merges the enabled lanes into the old word
    always_comb begin
        rd_word = old_word;
        if ((WRITE_FIRST != 0) && collide) begin
            for (int i = 0; i < NLANE; i++) begin
                if (wr_be[i]) begin
                    rd_word[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NLANE; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

`ifdef SRAM_DP_BE_PARITY_EN
    logic [NLANE-1:0] par [DEPTH];
    logic [NLANE-1:0] wr_par;
    logic [NLANE-1:0] old_par;
    logic [NLANE-1:0] rd_par;
    logic [NLANE-1:0] calc_par;
    logic             err_nx;

    assign old_par = par[rd_addr];

    always_comb begin
        wr_par   = '0;
        calc_par = '0;
        rd_par   = old_par;
        for (int i = 0; i < NLANE; i++) begin
            wr_par[i]   = (^wr_data[i*LANE_W +: LANE_W]) ^ wr_par_flip;
            calc_par[i] = ^rd_word[i*LANE_W +: LANE_W];
            if ((WRITE_FIRST != 0) && collide && wr_be[i]) begin
                rd_par[i] = wr_par[i];
            end
        end
    end

    assign err_nx = |(calc_par ^ rd_par);

    always_ff @(posedge clk) begin
        if (init_busy) begin
            par[cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NLANE; i++) begin
                if (wr_be[i]) begin
                    par[wr_addr][i] <= wr_par[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_err <= 1'b0;
        end else begin
            rd_err <= do_rd & err_nx;
        end
    end
`endif

    // Read register: data holds when no read is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_rd) begin
                rd_data <= rd_word;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = do_wr;

endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
- Parametrised simple dual-port SRAM: one write port, one read port, sharing one clock.
- Write port supports per-lane byte enables; read port has registered data with a valid strobe.
- Read/write collisions resolve according to a selectable mode.
- A built-in init sequencer zeroes the whole array after reset; sits wherever a small scratch buffer or register file is needed.

Parameters:
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, word width; must be a multiple of LANE_W.
- LANE_W, 4, bits per write-enable lane; NLANE = DATA_W/LANE_W.
- WRITE_FIRST, 1, collision mode: 1 = read returns newly written data, 0 = read returns old data.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- init_busy  out  1  high while the array is being cleared; ports ignored.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  NLANE  lane enables; bit i covers wr_data[i*LANE_W +: LANE_W].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle strobe: rd_data holds the result of the previous-cycle read.

Behaviour:
- Reset asserted (async): init_busy=1, rd_data=0, rd_valid=0, init counter=0, FSM=INIT. Array contents are not touched asynchronously.
- INIT state: each rising edge writes mem[cnt]=0 and increments cnt. The edge that writes DEPTH-1 moves the FSM to RUN and clears init_busy. init_busy is high for exactly DEPTH edges after reset release. The counter must not overflow for any ADDR_W (compare against DEPTH-1; do not rely on wrap).
- During INIT, wr_en and rd_en are ignored: no writes, rd_valid=0, rd_data holds 0.
- RUN write: on an edge with wr_en=1, each lane with wr_be[i]=1 takes the new data; other lanes keep their value. wr_be=0 is a no-op.
- RUN read: on an edge with rd_en=1, rd_data <= mem[rd_addr] and rd_valid <= 1. Latency is 1 cycle.
- On an edge with rd_en=0, rd_valid <= 0 and rd_data holds its last value.
- Back-to-back reads give one result per cycle.
- Collision (wr_en & rd_en & wr_addr==rd_addr, same edge):
  - WRITE_FIRST=1: rd_data takes the enabled lanes from wr_data and the remaining lanes from the old word.
  - WRITE_FIRST=0: rd_data is the old word.
  - In both modes the array is updated normally.
- Simultaneous read and write to different addresses are independent.
- Reset asserted mid-INIT or mid-RUN restarts INIT from address 0 on release. A read in flight is discarded (rd_valid=0).
- Addresses are always in range (2**ADDR_W words); no out-of-range handling.

Optional Feature:
- Macro: SRAM_DP_BE_PARITY_EN.
- Defined:
  - Each lane stores one extra even-parity bit, written alongside the lane data.
  - INIT writes parity 0.
  - Adds input wr_par_flip (1 bit): when high with wr_en, the stored parity of the enabled lanes is inverted (error injection).
  - Adds output rd_err (1 bit, reset 0): registered alongside rd_data; high when rd_valid=1 and any lane's recomputed parity mismatches the stored bit; 0 whenever rd_valid=0.
  - A collision read under WRITE_FIRST=1 checks the merged word using the parity being written.
- Undefined: no parity storage; wr_par_flip and rd_err ports do not exist.

Test Plan:
- Reset release, defaults -> init_busy high for 8 edges then low. Reading addresses 0..7 returns 0x00 with rd_valid high one cycle after each rd_en.
- Write addr 3 = 0xA5 with be=2'b11, then write addr 3 = 0x3C with be=2'b01, then read addr 3 -> rd_data=0xAC. Write with be=2'b00 leaves 0xAC.
- Collision: addr 5 holds 0x11; same edge write 0xEE be=2'b10 and read addr 5 -> WRITE_FIRST=1 returns 0xE1; WRITE_FIRST=0 returns 0x11. A later read returns 0xE1 in both modes.
- rd_en held high 4 cycles at addresses 0,1,2,3 -> 4 consecutive rd_valid pulses with the matching data. rd_en low -> rd_valid=0, rd_data unchanged.
- Assert rst at INIT edge 4, then again in RUN after writing addr 6 = 0xFF -> rd_valid drops immediately, init restarts for the full 8 edges, addr 6 reads 0x00.
- With SRAM_DP_BE_PARITY_EN: write addr 2 = 0x5A be=2'b01 with wr_par_flip=1, then read addr 2 -> rd_err=1. Rewrite with wr_par_flip=0 and read -> rd_err=0.
